// File: rtl/switch_debounce_sync.sv
// -----------------------------------------------------------------------------
// switch_debounce_sync
//
// Conditions the raw slider-switch pins ahead of the switch PIO slave. Each
// bit passes through a two-flop synchroniser and then a debouncer that only
// accepts a new level after it has been seen for DEBOUNCE_CYCLES consecutive
// clocks. Accepted transitions also produce one-cycle rise/fall pulses per
// bit plus a single aggregate "changed" pulse for edge-capture/IRQ logic.
//
// Parameters
//   WIDTH            number of switch bits
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to accept a level (>= 1)
//
// Ports
//   clk        in   1      system clock
//   reset_n    in   1      asynchronous, active-low reset
//   sw_raw     in   WIDTH  raw switch pins, asynchronous to clk
//   sw_stable  out  WIDTH  debounced level (registered)
//   sw_rise    out  WIDTH  one-cycle pulse per bit on accepted 0->1
//   sw_fall    out  WIDTH  one-cycle pulse per bit on accepted 1->0
//   changed    out  1      one-cycle pulse when any bit is accepted (registered)
// -----------------------------------------------------------------------------
module switch_debounce_sync #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  // A single-cycle window still needs a 1-bit counter so the compare is legal.
  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] mismatch_s;

  // Only the second synchroniser stage is ever looked at downstream.
  assign mismatch_s = sync2_q ^ stable_q;

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit window counting and acceptance; bits are fully independent.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (mismatch_s[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Window complete: take the new level and pulse in its direction.
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
          cnt_d[i]    = CNT_ZERO;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else begin
        // Any return to the accepted level drops the partial window.
        cnt_d[i] = CNT_ZERO;
      end
    end
    // Aggregated from the next-state pulses so it lands on the same edge.
    changed_d = |(rise_d | fall_d);
  end

  // Debounce state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_switch_debounce_sync.sv
module tb_switch_debounce_sync;

  localparam int W = 10;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         changed;

  int checks = 0;
  int errors = 0;

  switch_debounce_sync #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .sw_stable(sw_stable),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist holds sw_raw as sampled on each clock edge (newest last). The
  // level used for a decision at edge n is the raw sample from edge n-2.
  // A bit is accepted when the last D such samples all differ from the
  // currently accepted level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable  = '0;
  logic [W-1:0] m_rise    = '0;
  logic [W-1:0] m_fall    = '0;
  logic         m_changed = 1'b0;

  function automatic logic [W-1:0] window_diff();
    logic [W-1:0] acc;
    acc = '1;
    for (int d = 2; d <= D + 1; d++) acc &= hist[hist.size() - d] ^ m_stable;
    return acc;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_stable  <= '0;
      m_rise    <= '0;
      m_fall    <= '0;
      m_changed <= 1'b0;
      hist.delete();
      for (int i = 0; i <= D; i++) hist.push_back('0);
    end else begin
      m_stable  <= m_stable ^ window_diff();
      m_rise    <= window_diff() & hist[hist.size() - 2];
      m_fall    <= window_diff() & ~hist[hist.size() - 2];
      m_changed <= |window_diff();
      hist.push_back(sw_raw);
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_stable", sw_stable, m_stable);
    chk("cyc_rise", sw_rise, m_rise);
    chk("cyc_fall", sw_fall, m_fall);
    chk("cyc_changed", changed, m_changed);
  end

  // ---------------- directed stimulus ----------------
  logic         b5_pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [W-1:0] rise_log [10];
  logic [W-1:0] stab_log [10];
  logic         chg_log  [10];
  int           npulse;
  int           pulse_at;
  logic [W-1:0] acc_or;

  initial begin
    sw_raw  = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset state
    chk("rst_stable", sw_stable, 10'h000);
    chk("rst_rise", sw_rise, 10'h000);
    chk("rst_fall", sw_fall, 10'h000);
    chk("rst_changed", changed, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 2: single bit rise, accepted at edge k+5
    sw_raw = 10'h001;
    repeat (5) @(negedge clk);
    chk("t2_k4_stable", sw_stable, 10'h000);
    @(negedge clk);
    chk("t2_k5_stable", sw_stable, 10'h001);
    chk("t2_k5_rise", sw_rise, 10'h001);
    chk("t2_k5_changed", changed, 1'b1);
    chk("t2_k5_model", m_stable, 10'h001);
    @(negedge clk);
    chk("t2_k6_rise", sw_rise, 10'h000);
    chk("t2_k6_changed", changed, 1'b0);
    chk("t2_k6_stable", sw_stable, 10'h001);

    // 3: 3-cycle glitch on bit 3 is dropped
    sw_raw = 10'h009;
    repeat (3) @(negedge clk);
    sw_raw = 10'h001;
    acc_or = '0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      acc_or = acc_or | sw_rise | sw_fall | {{(W-1){1'b0}}, changed};
    end
    chk("t3_no_pulse", acc_or, 10'h000);
    chk("t3_stable", sw_stable, 10'h001);

    // 4: bounce on bit 5, single acceptance at edge offset 10
    npulse = 0;
    pulse_at = -1;
    for (int j = 0; j < 16; j++) begin
      if (j < 9) sw_raw[5] = b5_pat[j];
      @(negedge clk);
      if (sw_rise[5]) begin
        npulse++;
        pulse_at = j;
      end
    end
    chk("t4_rise_count", npulse, 1);
    chk("t4_rise_edge", pulse_at, 10);
    chk("t4_stable", sw_stable, 10'h021);
    chk("t4_model", m_stable, 10'h021);
    npulse = 0;
    pulse_at = -1;
    sw_raw[5] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (sw_fall[5]) begin
        npulse++;
        pulse_at = j;
      end
    end
    chk("t4_fall_count", npulse, 1);
    chk("t4_fall_edge", pulse_at, 5);
    chk("t4_fall_stable", sw_stable, 10'h001);

    // 5: simultaneous rises on bits 0 and 9, bit 4 two cycles later
    sw_raw = 10'h000;
    repeat (8) @(negedge clk);
    chk("t5_pre_stable", sw_stable, 10'h000);
    for (int j = 0; j < 10; j++) begin
      if (j == 0) sw_raw = 10'h201;
      if (j == 2) sw_raw = 10'h211;
      @(negedge clk);
      rise_log[j] = sw_rise;
      chg_log[j]  = changed;
    end
    chk("t5_rise5", rise_log[5], 10'h201);
    chk("t5_chg5", chg_log[5], 1'b1);
    chk("t5_rise6", rise_log[6], 10'h000);
    chk("t5_chg6", chg_log[6], 1'b0);
    chk("t5_rise7", rise_log[7], 10'h010);
    chk("t5_chg7", chg_log[7], 1'b1);
    chk("t5_stable", sw_stable, 10'h211);

    // 1b: asynchronous reset mid-run clears outputs before the next edge
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_stable", sw_stable, 10'h000);
    chk("async_rst_changed", changed, 1'b0);

    // 6a: all switches high at reset release
    sw_raw = 10'h3FF;
    repeat (2) @(negedge clk);
    chk("t6_inrst_stable", sw_stable, 10'h000);
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      stab_log[j] = sw_stable;
      rise_log[j] = sw_rise;
      chg_log[j]  = changed;
    end
    chk("t6_k4_stable", stab_log[4], 10'h000);
    chk("t6_k5_stable", stab_log[5], 10'h3FF);
    chk("t6_k5_rise", rise_log[5], 10'h3FF);
    chk("t6_k5_changed", chg_log[5], 1'b1);

    // 6b: reset at count 2 of a window loses the pending change
    #2 reset_n = 1'b0;
    sw_raw = 10'h000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    sw_raw = 10'h004;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6b_rst_stable", sw_stable, 10'h000);
    chk("t6b_rst_rise", sw_rise, 10'h000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      stab_log[j] = sw_stable;
      rise_log[j] = sw_rise;
    end
    acc_or = '0;
    for (int j = 0; j < 5; j++) acc_or = acc_or | rise_log[j] | stab_log[j];
    chk("t6b_no_early", acc_or, 10'h000);
    chk("t6b_k5_stable", stab_log[5], 10'h004);
    chk("t6b_k5_rise", rise_log[5], 10'h004);
    chk("t6b_k6_rise", rise_log[6], 10'h000);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
